// File: rtl/calc_operand_sequencer.sv
// Operand entry stage for the tiny calculator: synchronises and debounces KEY0, then latches A and B from SW[3:0].
// Optional macro CALC_OPERAND_SEQ_LIVE_PREVIEW_EN: shows the operand being entered live on o_operands.
module calc_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_sw,
    input  logic       i_key_n,
    output logic [7:0] o_operands,
    output logic [1:0] o_state,
    output logic [2:0] o_ledr,
    output logic       o_result_valid
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        SHOW    = 2'b10
    } state_e;

    logic [3:0]       sw_meta_q;
    logic [3:0]       sw_sync_q;
    logic             key_meta_q;
    logic             key_sync_q;
    logic             key_db_q;
    logic             key_db_d;
    logic             key_db_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       l_sw_s;
    logic             l_key_s;
    logic             l_press;

    state_e     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] ledr_q;
    logic       valid_q;

    assign l_sw_s  = sw_sync_q;
    assign l_key_s = key_sync_q;

    // Two-stage synchronisers; the key path idles at the released level (1).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            sw_meta_q  <= i_sw;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= i_key_n;
            key_sync_q <= key_meta_q;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        key_db_d = key_db_q;
        if (l_key_s == key_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            key_db_d = l_key_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q        <= '0;
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
        end
    end

    // One pulse per debounced press (falling edge of the active-low key).
    assign l_press = key_db_dly_q & ~key_db_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            ledr_q  <= 3'b001;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
                    a_q <= l_sw_s;
`endif
                    if (l_press) begin
                        a_q     <= l_sw_s;
                        state_q <= ENTER_B;
                        ledr_q  <= 3'b010;
                        valid_q <= 1'b0;
                    end
                end
                ENTER_B: begin
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
                    b_q <= l_sw_s;
`endif
                    if (l_press) begin
                        b_q     <= l_sw_s;
                        state_q <= SHOW;
                        ledr_q  <= 3'b100;
                        valid_q <= 1'b1;
                    end
                end
                SHOW: begin
                    if (l_press) begin
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= ENTER_A;
                        ledr_q  <= 3'b001;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding recovers to ENTER_A, operands kept.
                    state_q <= ENTER_A;
                    ledr_q  <= 3'b001;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_operands     = {b_q, a_q};
    assign o_state        = state_q;
    assign o_ledr         = ledr_q;
    assign o_result_valid = valid_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a short debounce window (4 cycles).
// Expected values for the live-preview build are selected with CALC_OPERAND_SEQ_LIVE_PREVIEW_EN.
module tb_calc_operand_sequencer;
    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic       key_n;
    logic [7:0] operands;
    logic [1:0] state;
    logic [2:0] ledr;
    logic       valid;

    int n_cmp = 0;
    int n_err = 0;

    calc_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_sw          (sw),
        .i_key_n       (key_n),
        .o_operands    (operands),
        .o_state       (state),
        .o_ledr        (ledr),
        .o_result_valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ops, input logic [1:0] st,
                           input logic [2:0] led, input logic v);
        chk({tag, ".ops"}, operands, ops);
        chk({tag, ".st"}, {6'd0, state}, {6'd0, st});
        chk({tag, ".led"}, {5'd0, ledr}, {5'd0, led});
        chk({tag, ".val"}, {7'd0, valid}, {7'd0, v});
    endtask

    task automatic press();
        key_n = 1'b0;
        tick(10);
        key_n = 1'b1;
        tick(10);
    endtask

    initial begin
        reset = 1'b1;
        sw    = 4'h0;
        key_n = 1'b1;

        // 1: reset
        tick(3);
        reset = 1'b0;
        tick(1);
        chk_all("reset", 8'h00, 2'b00, 3'b001, 1'b0);
        sw = 4'h5;
        tick(5);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("idle_sw", operands, 8'h05);
`else
        chk("idle_sw", operands, 8'h00);
`endif

        // 2: enter A=5, B=A, then clear
        press();
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk_all("latchA", 8'h55, 2'b01, 3'b010, 1'b0);
`else
        chk_all("latchA", 8'h05, 2'b01, 3'b010, 1'b0);
`endif
        sw = 4'hA;
        press();
        chk_all("latchB", 8'hA5, 2'b10, 3'b100, 1'b1);
        sw = 4'hF;
        tick(5);
        chk("show_hold", operands, 8'hA5);
        sw = 4'h0;
        press();
        chk_all("clear", 8'h00, 2'b00, 3'b001, 1'b0);

        // 3: bouncy press, advance exactly 7 edges after the last edge
        sw = 4'h6;
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            tick(2);
            key_n = 1'b1;
            tick(2);
        end
        chk("bounce_st", {6'd0, state}, 8'h00);
        key_n = 1'b0;
        tick(6);
        chk("lat_before", {6'd0, state}, 8'h00);
        tick(1);
        chk("lat_at", {6'd0, state}, 8'h01);
        chk("lat_ops", operands, 8'h06);
        key_n = 1'b1;
        tick(10);
        chk("release_st", {6'd0, state}, 8'h01);

        // 4: long hold then bouncy release
        sw = 4'h9;
        key_n = 1'b0;
        tick(100);
        chk_all("hold", 8'h96, 2'b10, 3'b100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b1;
            tick(2);
            key_n = 1'b0;
            tick(2);
        end
        key_n = 1'b1;
        tick(20);
        chk_all("rel_bounce", 8'h96, 2'b10, 3'b100, 1'b1);
        sw = 4'h0;
        press();
        chk("back_A", {6'd0, state}, 8'h00);

        // 5: reset in the middle of a debounce window in ENTER_B
        sw = 4'h3;
        press();
        chk("pre5_st", {6'd0, state}, 8'h01);
        key_n = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        chk_all("mid_reset", 8'h00, 2'b00, 3'b001, 1'b0);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b1;
            tick(2);
            key_n = 1'b0;
            tick(2);
        end
        key_n = 1'b1;
        tick(20);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk_all("post_reset", 8'h03, 2'b00, 3'b001, 1'b0);
`else
        chk_all("post_reset", 8'h00, 2'b00, 3'b001, 1'b0);
`endif

        // 6: live preview tracking (static operands in the default build)
        sw = 4'h1;
        tick(4);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("pv_1", operands, 8'h01);
`else
        chk("pv_1", operands, 8'h00);
`endif
        sw = 4'h7;
        tick(4);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("pv_7", operands, 8'h07);
`else
        chk("pv_7", operands, 8'h00);
`endif
        sw = 4'hC;
        tick(4);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("pv_C", operands, 8'h0C);
`else
        chk("pv_C", operands, 8'h00);
`endif
        press();
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("pv_press", operands, 8'hCC);
`else
        chk("pv_press", operands, 8'h0C);
`endif
        sw = 4'h2;
        tick(4);
`ifdef CALC_OPERAND_SEQ_LIVE_PREVIEW_EN
        chk("pv_B2", operands, 8'h2C);
`else
        chk("pv_B2", operands, 8'h0C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
